// File: rtl/maze_probe_scheduler_if.sv
// Maze-map read port between the probe scheduler (master) and the map ROM arbiter (slave).
// The master holds map_x/map_y stable while map_req is high, until it samples map_ack.
interface maze_probe_scheduler_if #(
    parameter int XW    = 9,
    parameter int YW    = 9,
    parameter int PIX_W = 3
);
    logic             map_req;
    logic [XW-1:0]    map_x;
    logic [YW-1:0]    map_y;
    logic             map_ack;
    logic [PIX_W-1:0] map_pixel;

    modport master (output map_req, map_x, map_y, input map_ack, map_pixel);
    modport slave  (input map_req, map_x, map_y, output map_ack, map_pixel);
endinterface

// File: rtl/maze_probe_scheduler.sv
// Time-multiplexed collision checker: snapshots all actor channels on start, probes the map
// one channel at a time over a req/ack port, and publishes every collide flag together at done.
module maze_probe_scheduler #(
    parameter int N_CH        = 4,
    parameter int XW          = 9,
    parameter int YW          = 9,
    parameter int PIX_W       = 3,
    parameter int MAP_W       = 320,
    parameter int MAP_H       = 320,
    parameter int PROBE_DIST  = 1,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*N_CH-1:0]    dir_flat,
    input  logic [XW*N_CH-1:0]   pos_x_flat,
    input  logic [YW*N_CH-1:0]   pos_y_flat,
    output logic                 busy,
    output logic                 done,
    output logic [N_CH-1:0]      collide,
    output logic [N_CH-1:0]      timeout_err,
    maze_probe_scheduler_if.master mbus
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, PROBE, FINISH} state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [TW-1:0]            tmo_q, tmo_d;
    logic [N_CH-1:0][3:0]     dir_s_q, dir_s_d;
    logic [N_CH-1:0][XW-1:0]  x_s_q, x_s_d;
    logic [N_CH-1:0][YW-1:0]  y_s_q, y_s_d;
    logic [N_CH-1:0]          coll_sh_q, coll_sh_d;
    logic [N_CH-1:0]          terr_sh_q, terr_sh_d;
    logic [N_CH-1:0]          collide_q, collide_d;
    logic [N_CH-1:0]          terr_q, terr_d;

    // One extra bit so that x-1 at x=0 wraps to a value that also fails the >= MAP_W test
    logic [XW:0] px;
    logic [YW:0] py;
    logic        dir_ok, oor, req, resolve, keep, res_coll, res_terr;

    always_comb begin
        px     = {1'b0, x_s_q[idx_q]};
        py     = {1'b0, y_s_q[idx_q]};
        dir_ok = 1'b1;
        case (dir_s_q[idx_q])
            4'b1000: px = {1'b0, x_s_q[idx_q]} - (XW+1)'(PROBE_DIST);
            4'b0100: py = {1'b0, y_s_q[idx_q]} - (YW+1)'(PROBE_DIST);
            4'b0010: px = {1'b0, x_s_q[idx_q]} + (XW+1)'(PROBE_DIST);
            4'b0001: py = {1'b0, y_s_q[idx_q]} + (YW+1)'(PROBE_DIST);
            default: dir_ok = 1'b0;
        endcase
        oor = (px >= (XW+1)'(MAP_W)) || (py >= (YW+1)'(MAP_H));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tmo_d     = tmo_q;
        dir_s_d   = dir_s_q;
        x_s_d     = x_s_q;
        y_s_d     = y_s_q;
        coll_sh_d = coll_sh_q;
        terr_sh_d = terr_sh_q;
        collide_d = collide_q;
        terr_d    = terr_q;
        req       = 1'b0;
        resolve   = 1'b0;
        keep      = 1'b0;
        res_coll  = 1'b0;
        res_terr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < N_CH; i++) begin
                        dir_s_d[i] = dir_flat[4*i +: 4];
                        x_s_d[i]   = pos_x_flat[XW*i +: XW];
                        y_s_d[i]   = pos_y_flat[YW*i +: YW];
                    end
                    idx_d     = '0;
                    tmo_d     = '0;
                    coll_sh_d = collide_q;
                    terr_sh_d = '0;
                    state_d   = PROBE;
                end
            end
            PROBE: begin
                if (!dir_ok) begin
                    resolve = 1'b1;
                    keep    = 1'b1;
                end else if (oor) begin
                    resolve  = 1'b1;
                    res_coll = 1'b1;
                end else begin
                    req = 1'b1;
                    if (mbus.map_ack) begin
                        resolve  = 1'b1;
                        res_coll = (mbus.map_pixel == '0);
                    end else if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
                        resolve  = 1'b1;
                        res_coll = 1'b1;
                        res_terr = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                if (resolve) begin
                    tmo_d = '0;
                    if (!keep) coll_sh_d[idx_q] = res_coll;
                    terr_sh_d[idx_q] = res_terr;
                    // Publish on the edge into FINISH so the flags appear with done
                    if (idx_q == IW'(N_CH - 1)) begin
                        state_d   = FINISH;
                        collide_d = coll_sh_d;
                        terr_d    = terr_sh_d;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            tmo_q     <= '0;
            dir_s_q   <= '0;
            x_s_q     <= '0;
            y_s_q     <= '0;
            coll_sh_q <= '0;
            terr_sh_q <= '0;
            collide_q <= '0;
            terr_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            dir_s_q   <= dir_s_d;
            x_s_q     <= x_s_d;
            y_s_q     <= y_s_d;
            coll_sh_q <= coll_sh_d;
            terr_sh_q <= terr_sh_d;
            collide_q <= collide_d;
            terr_q    <= terr_d;
        end
    end

    assign busy         = (state_q == PROBE);
    assign done         = (state_q == FINISH);
    assign collide      = collide_q;
    assign timeout_err  = terr_q;
    assign mbus.map_req = req;
    assign mbus.map_x   = req ? px[XW-1:0] : '0;
    assign mbus.map_y   = req ? py[YW-1:0] : '0;
endmodule

// File: tb/tb_maze_probe_scheduler.sv
// Directed bench for maze_probe_scheduler: a small map model with one wall pixel and a
// configurable ack policy (always / fixed delay / never) drives each scenario task.
module tb_maze_probe_scheduler;
    localparam int N_CH = 4, XW = 9, YW = 9, PIX_W = 3;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [4*N_CH-1:0]  dir_flat = '0;
    logic [XW*N_CH-1:0] pos_x_flat = '0;
    logic [YW*N_CH-1:0] pos_y_flat = '0;
    logic               busy, done;
    logic [N_CH-1:0]    collide, timeout_err;

    int checks = 0, errors = 0;

    logic             ack_always = 1'b0, ack_en = 1'b0;
    int               ack_delay = 0, wait_cnt = 0;
    logic [XW-1:0]    wall_x = '1;
    logic [YW-1:0]    wall_y = '1;
    logic [PIX_W-1:0] pix_other = 3'd5;

    maze_probe_scheduler_if #(.XW(XW), .YW(YW), .PIX_W(PIX_W)) mif ();

    maze_probe_scheduler #(.N_CH(N_CH), .XW(XW), .YW(YW), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dir_flat(dir_flat),
        .pos_x_flat(pos_x_flat), .pos_y_flat(pos_y_flat), .busy(busy), .done(done),
        .collide(collide), .timeout_err(timeout_err), .mbus(mif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mif.map_req && !mif.map_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;

    assign mif.map_ack   = ack_always | (ack_en & mif.map_req & (wait_cnt >= ack_delay));
    assign mif.map_pixel = (mif.map_x == wall_x && mif.map_y == wall_y) ? '0 : pix_other;

    task automatic set_ch(input int i, input logic [3:0] d, input int x, input int y);
        dir_flat[4*i +: 4]    = d;
        pos_x_flat[XW*i +: XW] = XW'(x);
        pos_y_flat[YW*i +: YW] = YW'(y);
    endtask

    // Returns at the first negedge after the sampling edge (scan cycle k=1)
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, mif.map_req} !== 3'b000) begin errors++;
            $display("FAIL rst_ctrl got %b want 000", {busy, done, mif.map_req}); end
        checks++; if ({collide, timeout_err} !== 8'h00) begin errors++;
            $display("FAIL rst_flags got %h want 00", {collide, timeout_err}); end
        checks++; if ({mif.map_x, mif.map_y} !== 18'd0) begin errors++;
            $display("FAIL rst_xy got %0d/%0d want 0/0", mif.map_x, mif.map_y); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle got %b want 0", busy); end
    endtask

    task automatic test_immediate();
        int k;
        ack_always = 1'b1; ack_en = 1'b0; wall_x = 9'd99; wall_y = 9'd50; pix_other = 3'd5;
        set_ch(0, 4'b1000, 100, 50); set_ch(1, 4'b0010, 10, 10);
        set_ch(2, 4'b0100, 20, 20);  set_ch(3, 4'b0001, 30, 30);
        pulse_start();
        k = 1;
        while (!done && k < 200) begin
            if (k == 1) begin
                checks++; if ({busy, mif.map_req, mif.map_x, mif.map_y} !== {2'b11, 9'd99, 9'd50}) begin errors++;
                    $display("FAIL imm_ch0 got b%b r%b %0d,%0d want 1 1 99,50", busy, mif.map_req, mif.map_x, mif.map_y); end
            end
            if (k == 2) begin
                checks++; if ({mif.map_req, mif.map_x, mif.map_y} !== {1'b1, 9'd11, 9'd10}) begin errors++;
                    $display("FAIL imm_ch1 got r%b %0d,%0d want 1 11,10", mif.map_req, mif.map_x, mif.map_y); end
            end
            @(negedge clk); k++;
        end
        checks++; if (k !== 5 || done !== 1'b1) begin errors++; $display("FAIL imm_latency got %0d want 5", k); end
        checks++; if ({busy, collide, timeout_err} !== {1'b0, 4'b0001, 4'b0000}) begin errors++;
            $display("FAIL imm_result got b%b c%b t%b want b0 c0001 t0000", busy, collide, timeout_err); end
    endtask

    task automatic test_boundary();
        int k;
        wall_x = 9'd5; wall_y = 9'd4;
        set_ch(0, 4'b0010, 200, 100); set_ch(1, 4'b1000, 0, 7);
        set_ch(2, 4'b0001, 40, 319);  set_ch(3, 4'b0100, 5, 5);
        pulse_start();
        k = 1;
        while (!done && k < 200) begin
            if (k == 2 || k == 3) begin
                checks++; if (mif.map_req !== 1'b0) begin errors++;
                    $display("FAIL bnd_skip_req k=%0d got %b want 0", k, mif.map_req); end
            end
            if (k == 4) begin
                checks++; if ({mif.map_req, mif.map_x, mif.map_y, collide} !== {1'b1, 9'd5, 9'd4, 4'b0001}) begin errors++;
                    $display("FAIL bnd_ch3 got r%b %0d,%0d c%b want 1 5,4 c0001", mif.map_req, mif.map_x, mif.map_y, collide); end
            end
            @(negedge clk); k++;
        end
        checks++; if (k !== 5) begin errors++; $display("FAIL bnd_latency got %0d want 5", k); end
        checks++; if ({collide, timeout_err} !== {4'b1110, 4'b0000}) begin errors++;
            $display("FAIL bnd_result got c%b t%b want c1110 t0000", collide, timeout_err); end
    endtask

    task automatic test_wait_states();
        int k;
        ack_always = 1'b0; ack_en = 1'b1; ack_delay = 3;
        wall_x = '1; wall_y = '1; pix_other = 3'd2;
        set_ch(0, 4'b0010, 50, 60); set_ch(1, 4'b0001, 10, 10);
        set_ch(2, 4'b1000, 0, 30);  set_ch(3, 4'b0100, 30, 0);
        pulse_start();
        // Scrambled live inputs must not disturb the snapshot
        dir_flat = '0; pos_x_flat = '1; pos_y_flat = '1;
        k = 1;
        while (!done && k < 200) begin
            if (k <= 4) begin
                checks++; if ({mif.map_req, mif.map_x, mif.map_y} !== {1'b1, 9'd51, 9'd60}) begin errors++;
                    $display("FAIL wait_hold k=%0d got r%b %0d,%0d want 1 51,60", k, mif.map_req, mif.map_x, mif.map_y); end
            end
            if (k == 5) begin
                checks++; if ({mif.map_req, mif.map_x, mif.map_y} !== {1'b1, 9'd10, 9'd11}) begin errors++;
                    $display("FAIL wait_ch1 got r%b %0d,%0d want 1 10,11", mif.map_req, mif.map_x, mif.map_y); end
            end
            @(negedge clk); k++;
        end
        checks++; if (k !== 11) begin errors++; $display("FAIL wait_latency got %0d want 11", k); end
        checks++; if ({collide, timeout_err} !== {4'b1100, 4'b0000}) begin errors++;
            $display("FAIL wait_result got c%b t%b want c1100 t0000", collide, timeout_err); end
    endtask

    task automatic test_timeout();
        int k;
        ack_always = 1'b0; ack_en = 1'b0;
        set_ch(0, 4'b0010, 10, 10); set_ch(1, 4'b1000, 10, 10);
        set_ch(2, 4'b0100, 10, 10); set_ch(3, 4'b0001, 10, 10);
        pulse_start();
        k = 1;
        while (!done && k < 200) begin
            if (k == 15) begin
                checks++; if ({mif.map_req, mif.map_x} !== {1'b1, 9'd11}) begin errors++;
                    $display("FAIL tmo_ch0_last got r%b x%0d want 1 11", mif.map_req, mif.map_x); end
            end
            if (k == 16) begin
                checks++; if ({mif.map_req, mif.map_x} !== {1'b1, 9'd9}) begin errors++;
                    $display("FAIL tmo_ch1_first got r%b x%0d want 1 9", mif.map_req, mif.map_x); end
            end
            @(negedge clk); k++;
        end
        checks++; if (k !== 61) begin errors++; $display("FAIL tmo_latency got %0d want 61", k); end
        checks++; if ({collide, timeout_err} !== {4'b1111, 4'b1111}) begin errors++;
            $display("FAIL tmo_result got c%b t%b want c1111 t1111", collide, timeout_err); end
    endtask

    task automatic test_invalid_dir();
        int k, extra;
        ack_always = 1'b1; pix_other = 3'd5;
        set_ch(0, 4'b0010, 10, 10); set_ch(1, 4'b0001, 20, 20);
        set_ch(2, 4'b0100, 30, 30); set_ch(3, 4'b0000, 40, 40);
        pulse_start();
        k = 1;
        while (!done && k < 200) begin
            start = (k == 2);
            if (k == 4) begin
                checks++; if (mif.map_req !== 1'b0) begin errors++;
                    $display("FAIL inv_no_access got %b want 0", mif.map_req); end
            end
            @(negedge clk); k++;
        end
        checks++; if (k !== 5) begin errors++; $display("FAIL inv_latency got %0d want 5", k); end
        checks++; if ({collide, timeout_err} !== {4'b1000, 4'b0000}) begin errors++;
            $display("FAIL inv_result got c%b t%b want c1000 t0000", collide, timeout_err); end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_finish_start got %b want 0", busy); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL inv_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_async_reset();
        int k, dn;
        ack_always = 1'b0; ack_en = 1'b1; ack_delay = 3;
        set_ch(0, 4'b0010, 10, 10); set_ch(1, 4'b0010, 20, 20);
        set_ch(2, 4'b0010, 30, 30); set_ch(3, 4'b0010, 40, 40);
        pulse_start();
        repeat (9) @(negedge clk);
        checks++; if ({busy, mif.map_req, mif.map_x} !== {2'b11, 9'd31}) begin errors++;
            $display("FAIL ar_pre got b%b r%b x%0d want 1 1 31", busy, mif.map_req, mif.map_x); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({busy, mif.map_req, collide, timeout_err} !== 10'd0) begin errors++;
            $display("FAIL ar_clear got b%b r%b c%b t%b want all 0", busy, mif.map_req, collide, timeout_err); end
        dn = 0;
        repeat (3) begin @(negedge clk); if (done) dn++; end
        checks++; if (dn !== 0) begin errors++; $display("FAIL ar_no_done got %0d want 0", dn); end
        rst_n = 1'b1;
        ack_always = 1'b1; ack_en = 1'b0; wall_x = 9'd99; wall_y = 9'd50; pix_other = 3'd5;
        set_ch(0, 4'b1000, 100, 50); set_ch(1, 4'b0010, 10, 10);
        set_ch(2, 4'b0100, 20, 20);  set_ch(3, 4'b0000, 30, 30);
        pulse_start();
        k = 1;
        while (!done && k < 200) begin @(negedge clk); k++; end
        checks++; if (k !== 5) begin errors++; $display("FAIL ar_rescan_latency got %0d want 5", k); end
        checks++; if ({collide, timeout_err} !== {4'b0001, 4'b0000}) begin errors++;
            $display("FAIL ar_rescan_result got c%b t%b want c0001 t0000", collide, timeout_err); end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_boundary();
        test_wait_states();
        test_timeout();
        test_invalid_dir();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/maze_probe_scheduler.md
Name: maze_probe_scheduler

Overview:
Time-multiplexed, parametrised collision checker for all moving actors (Pac-Man plus ghosts) sharing one maze-map read port. On each `start` it snapshots every channel's position and one-hot direction. It then probes the map pixel PROBE_DIST ahead of each actor over a req/ack handshake and publishes all collide flags atomically. It sits between the actor movement logic and the maze-map ROM arbiter, and generalises the single-actor, fixed-latency direction check.

Parameters:
N_CH, 4, number of actor channels (1..8); channel 0 has highest scan priority (scanned first)
XW, 9, x coordinate width
YW, 9, y coordinate width
PIX_W, 3, map pixel width; pixel value 0 = wall
MAP_W, 320, map width in pixels; valid x range 0..MAP_W-1
MAP_H, 320, map height in pixels; valid y range 0..MAP_H-1
PROBE_DIST, 1, probe offset in pixels along the direction of travel
ACK_TIMEOUT, 15, max cycles map_req may wait for map_ack

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  scan request pulse; sampled only when busy=0
dir_flat  in  4*N_CH  per-channel direction, one-hot: 1000=L, 0100=U, 0010=R, 0001=D; channel i at [4i+3:4i]
pos_x_flat  in  XW*N_CH  per-channel x position
pos_y_flat  in  YW*N_CH  per-channel y position
busy  out  1  scan in progress
done  out  1  one-cycle pulse; collide/timeout_err updated this cycle
collide  out  N_CH  1 = probe pixel in requested direction is wall/out-of-map
timeout_err  out  N_CH  1 = map read for that channel timed out in last scan
map_req  out  1  map read request
map_x  out  XW  probe x coordinate, valid while map_req=1
map_y  out  YW  probe y coordinate, valid while map_req=1
map_ack  in  1  map read complete; map_pixel valid in same cycle
map_pixel  in  PIX_W  map pixel value

Behaviour:
- Reset (async, rst_n=0): busy=0, done=0, collide=0, timeout_err=0, map_req=0, map_x=0, map_y=0, FSM=IDLE, channel index=0, timeout counter=0.
- Reset asserted mid-scan aborts the scan immediately. No done pulse. Partial results are discarded.
- FSM states: IDLE, PROBE, FINISH.
- IDLE: if start=1 at edge T, snapshot dir/pos of all channels, index=0, go to PROBE. busy=1 from T+1.
- start while busy=1 is ignored; no queueing.
- Inputs changing during a scan have no effect; only the snapshot is used.
- PROBE, per channel (index i), compute the probe point from the snapshot:
  - L: x-PROBE_DIST
  - R: x+PROBE_DIST
  - U: y-PROBE_DIST
  - D: y+PROBE_DIST
  - Arithmetic is one bit wider than XW/YW to detect underflow/overflow.
- Skip cases resolve in 1 cycle with map_req=0, then advance:
  - Probe point negative or >= MAP_W / MAP_H: result collide=1, timeout_err=0.
  - Direction not one-hot (incl. 0000): collide bit keeps its previous published value, timeout_err=0.
- Otherwise assert map_req with map_x/map_y. Hold both stable until map_ack=1 is sampled.
- map_ack may arrive in the same cycle as map_req: 1-cycle resolve. On ack, result = (map_pixel==0). map_req drops the next cycle unless the next channel also issues. Back-to-back channels may keep map_req high with new coordinates.
- map_ack while map_req=0 is ignored.
- Timeout: counter counts cycles with map_req=1 and no ack. On reaching ACK_TIMEOUT, result collide=1, timeout_err=1, deassert map_req, advance.
  - A late ack for the abandoned request, arriving while the next channel's request is pending, is indistinguishable from a real ack and is accepted. Map slaves must not ack after dropping out.
- After channel N_CH-1 resolves → FINISH.
- FINISH (1 cycle): done=1; collide and timeout_err load from shadow registers simultaneously; busy=0 in this same cycle; → IDLE.
- start sampled in the FINISH cycle is ignored; a new start is accepted from the next cycle.
- Published collide/timeout_err never change except at done, and hold between scans.
- Minimum scan length: N_CH+1 cycles from start to done (all acks immediate, or all skips).

Test Plan:
- Immediate-ack scan: N_CH=4, ch0 L at (100,50), map returns pixel 0 for (99,50) and 5 elsewhere, ack tied high → map_x sequence 99 for ch0; done 5 cycles after start edge; collide=0001; timeout_err=0000.
- Boundary: ch1 L at x=0 and ch2 D at y=319 → no map_req for ch1/ch2; collide[1]=1, collide[2]=1; ch1 and ch2 each take 1 cycle.
- Wait states: ack delayed 3 cycles on ch0 → map_req and map_x/map_y stable for 4 cycles; pixel=2 → collide[0]=0.
- Timeout: map_ack never asserted → each channel holds map_req 15 cycles; collide=1111, timeout_err=1111; done at cycle ~4*15+1.
- Invalid dir: ch3 dir=0000 after a previous scan with collide[3]=1 → collide[3] stays 1, no map access; start pulsed mid-scan → ignored, exactly one done.
- Async reset: rst_n low during ch2 wait → busy, map_req, collide, timeout_err all 0 immediately, no done; next start runs a full clean scan.
